// File: rtl/scie_issue_sequencer_pkg.sv
// Shared types and constants for the SCIE issue sequencer: widths, opcodes,
// FSM state encoding and the complex sample/result word.
package scie_pkg;

   localparam int DATA_W = 16;
   localparam int INSN_W = 32;
   localparam int RS2_W  = 32;
   localparam int CNT_W  = 8;

   localparam logic [INSN_W-1:0] INSN_INIT = 32'h0000_000B;
   localparam logic [INSN_W-1:0] INSN_LOAD = 32'h0000_002B;
   localparam logic [INSN_W-1:0] INSN_READ = 32'h0000_005B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_LOAD,
      ST_GAP,
      ST_READ,
      ST_WAIT
   } state_t;

   // "real" is a reserved word, hence re/im
   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

endpackage

// File: rtl/scie_issue_sequencer_if.sv
// Bundle of configuration, sample/result streams and the SCIE issue bus.
// master = sequencer side, slave = surrounding system (source, sink, SCIE unit).
interface scie_issue_sequencer_if;
   import scie_pkg::*;

   logic              cfg_start;
   logic [DATA_W-1:0] cfg_real;
   logic [DATA_W-1:0] cfg_imag;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_real;
   logic [DATA_W-1:0] s_imag;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_real;
   logic [DATA_W-1:0] m_imag;

   logic              io_valid;
   logic [INSN_W-1:0] io_insn;
   logic [DATA_W-1:0] io_rs1_real;
   logic [DATA_W-1:0] io_rs1_imag;
   logic [RS2_W-1:0]  io_rs2;
   logic [DATA_W-1:0] io_rd_real;
   logic [DATA_W-1:0] io_rd_imag;

   logic              busy;
   logic [15:0]       done_cnt;

   modport master (
      input  cfg_start, cfg_real, cfg_imag,
      input  s_valid, s_real, s_imag,
      output s_ready,
      output m_valid, m_real, m_imag,
      input  m_ready,
      output io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
      input  io_rd_real, io_rd_imag,
      output busy, done_cnt
   );

   modport slave (
      output cfg_start, cfg_real, cfg_imag,
      output s_valid, s_real, s_imag,
      input  s_ready,
      input  m_valid, m_real, m_imag,
      output m_ready,
      input  io_valid, io_insn, io_rs1_real, io_rs1_imag, io_rs2,
      output io_rd_real, io_rd_imag,
      input  busy, done_cnt
   );

endinterface

// File: rtl/scie_issue_sequencer_fifo.sv
// Show-ahead result FIFO holding captured SCIE results until the sink pops them.
module scie_result_fifo
   import scie_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  cplx_t                  push_data,
   input  logic                   pop,
   output cplx_t                  head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   cplx_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/scie_issue_sequencer.sv
// Initiator for the SCIE pipelined custom-instruction port: issues INIT once,
// then LOAD / gap / READ per sample and queues the returned results.
//
//   state | meaning
//   IDLE  | waiting for cfg_start
//   INIT  | INIT instruction on the bus with the cfg operand
//   RUN   | ready for a sample (if a result slot is free) or a re-init
//   LOAD  | LOAD instruction on the bus with the accepted sample
//   GAP   | GAP_CYC idle cycles before READ
//   READ  | READ instruction on the bus
//   WAIT  | RD_LAT cycles; last one captures io_rd into the FIFO
module scie_issue_sequencer
   import scie_pkg::*;
#(
   parameter int GAP_CYC   = 1,
   parameter int RD_LAT    = 1,
   parameter int RES_DEPTH = 2
) (
   input logic                    clock,
   input logic                    reset,
   scie_issue_sequencer_if.master bus
);

   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [CW-1:0]     resv;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       occupancy;
   logic              fifo_full;
   logic              fifo_empty;
   logic              slot_free;
   logic              accept;
   logic              restart;
   logic              capture;
   logic              pop;
   logic              issue_valid;
   logic [INSN_W-1:0] issue_insn;
   cplx_t             rs1;
   cplx_t             head;
   logic [15:0]       done_count;

   // A slot is claimed at accept so the capture in WAIT can never find the FIFO full
   assign occupancy = {1'b0, fifo_count} + {1'b0, resv};
   assign slot_free = !fifo_full && (occupancy < (CW+1)'(RES_DEPTH));
   assign accept    = (state == ST_RUN) && slot_free && bus.s_valid;
   assign restart   = (state == ST_RUN) && bus.cfg_start && fifo_empty && !bus.s_valid;
   assign capture   = (state == ST_WAIT) && (cnt == '0);
   assign pop       = !fifo_empty && bus.m_ready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         resv        <= '0;
         done_count  <= '0;
         issue_valid <= 1'b0;
         issue_insn  <= '0;
         rs1         <= '0;
      end else begin
         issue_valid <= 1'b0;
         issue_insn  <= '0;
         case (state)
            ST_IDLE, ST_RUN: begin
               if (state == ST_RUN && accept) begin
                  state       <= ST_LOAD;
                  issue_valid <= 1'b1;
                  issue_insn  <= INSN_LOAD;
                  rs1         <= {bus.s_real, bus.s_imag};
                  resv        <= resv + 1'b1;
               end else if ((state == ST_IDLE && bus.cfg_start) || restart) begin
                  state       <= ST_INIT;
                  issue_valid <= 1'b1;
                  issue_insn  <= INSN_INIT;
                  rs1         <= {bus.cfg_real, bus.cfg_imag};
                  done_count  <= '0;
               end
            end
            ST_INIT: state <= ST_RUN;
            ST_LOAD: begin
               state <= ST_GAP;
               cnt   <= GAP_LOAD;
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  state       <= ST_READ;
                  issue_valid <= 1'b1;
                  issue_insn  <= INSN_READ;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_READ: begin
               state <= ST_WAIT;
               cnt   <= LAT_LOAD;
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state      <= ST_RUN;
                  resv       <= resv - 1'b1;
                  done_count <= done_count + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   scie_result_fifo #(
      .DEPTH (RES_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (capture),
      .push_data ({bus.io_rd_real, bus.io_rd_imag}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.s_ready     = (state == ST_RUN) && slot_free;
   assign bus.m_valid     = !fifo_empty;
   assign bus.m_real      = head.re;
   assign bus.m_imag      = head.im;
   assign bus.io_valid    = issue_valid;
   assign bus.io_insn     = issue_insn;
   assign bus.io_rs1_real = rs1.re;
   assign bus.io_rs1_imag = rs1.im;
   assign bus.io_rs2      = '0;
   assign bus.busy        = (state != ST_IDLE) && (state != ST_RUN);
   assign bus.done_cnt    = done_count;

endmodule

// File: tb/tb_scie_issue_sequencer.sv
// Directed bench for scie_issue_sequencer against a behavioural SCIE unit
// that returns (sample * cfg) >>> 4 one cycle after READ.
module tb_scie_issue_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   res_re[$];
   int   res_im[$];
   int   res_cyc[$];
   int   base;
   logic signed [15:0] cfg_re, cfg_im, smp_re, smp_im;

   scie_issue_sequencer_if bus ();

   scie_issue_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] cmul(input int ar, input int ai, input int br, input int bi);
      int pr;
      int pi;
      pr = ar * br - ai * bi;
      pi = ar * bi + ai * br;
      return {16'(pr >>> 4), 16'(pi >>> 4)};
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         cfg_re <= '0;
         cfg_im <= '0;
         smp_re <= '0;
         smp_im <= '0;
         bus.io_rd_real <= '0;
         bus.io_rd_imag <= '0;
      end else if (bus.io_valid) begin
         case (bus.io_insn)
            32'h0B: begin
               cfg_re <= bus.io_rs1_real;
               cfg_im <= bus.io_rs1_imag;
            end
            32'h2B: begin
               smp_re <= bus.io_rs1_real;
               smp_im <= bus.io_rs1_imag;
            end
            32'h5B: {bus.io_rd_real, bus.io_rd_imag} <= cmul(int'(smp_re), int'(smp_im), int'(cfg_re), int'(cfg_im));
            default: ;
         endcase
      end
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
      if (bus.m_valid && bus.m_ready) begin
         res_re.push_back(int'($signed(bus.m_real)));
         res_im.push_back(int'($signed(bus.m_imag)));
         res_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic set_cfg(input int re, input int im);
      bus.cfg_real = 16'(re);
      bus.cfg_imag = 16'(im);
   endtask

   task automatic set_smp(input int re, input int im);
      bus.s_real = 16'(re);
      bus.s_imag = 16'(im);
   endtask

   task automatic wait_accept(input string tag, input int target);
      int k = 0;
      while (acc_cnt < target && k < 40) begin
         tick(1);
         k++;
      end
      check(tag, acc_cnt, target);
   endtask

   task automatic wait_results(input string tag, input int n);
      int k = 0;
      while (res_re.size() < n && k < 60) begin
         tick(1);
         k++;
      end
      check(tag, res_re.size(), n);
   endtask

   task automatic check_res(input string tag, input int i, input int re, input int im);
      if (i < res_re.size()) begin
         check({tag, "_re"}, res_re[i], re);
         check({tag, "_im"}, res_im[i], im);
      end
   endtask

   task automatic clear_results();
      res_re.delete();
      res_im.delete();
      res_cyc.delete();
   endtask

   initial begin
      bus.cfg_start = 1'b0;
      set_cfg(0, 0);
      bus.s_valid = 1'b0;
      set_smp(0, 0);
      bus.m_ready = 1'b0;
      tick(2);

      check("rst_io_valid", int'(bus.io_valid), 0);
      check("rst_io_insn", int'(bus.io_insn), 0);
      check("rst_s_ready", int'(bus.s_ready), 0);
      check("rst_m_valid", int'(bus.m_valid), 0);
      check("rst_m_real", int'(bus.m_real), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done_cnt", int'(bus.done_cnt), 0);
      check("rst_io_rs2", int'(bus.io_rs2), 0);

      reset = 1'b1;
      tick(1);
      check("idle_s_ready", int'(bus.s_ready), 0);

      // INIT
      set_cfg(-88, -452);
      bus.cfg_start = 1'b1;
      tick(1);
      bus.cfg_start = 1'b0;
      check("init_io_valid", int'(bus.io_valid), 1);
      check("init_io_insn", int'(bus.io_insn), 'h0B);
      check("init_busy", int'(bus.busy), 1);
      check("init_rs1_re", int'($signed(bus.io_rs1_real)), -88);
      check("init_rs1_im", int'($signed(bus.io_rs1_imag)), -452);
      tick(1);
      check("run_busy", int'(bus.busy), 0);
      check("run_io_valid", int'(bus.io_valid), 0);
      check("run_io_insn", int'(bus.io_insn), 0);
      check("run_rs1_hold", int'($signed(bus.io_rs1_real)), -88);
      check("run_s_ready", int'(bus.s_ready), 1);

      // single sample
      set_smp(77, -645);
      bus.s_valid = 1'b1;
      tick(1);
      bus.s_valid = 1'b0;
      check("load_io_valid", int'(bus.io_valid), 1);
      check("load_io_insn", int'(bus.io_insn), 'h2B);
      check("load_rs1_re", int'($signed(bus.io_rs1_real)), 77);
      check("load_rs1_im", int'($signed(bus.io_rs1_imag)), -645);
      check("load_s_ready", int'(bus.s_ready), 0);
      tick(1);
      check("gap_io_valid", int'(bus.io_valid), 0);
      check("gap_io_insn", int'(bus.io_insn), 0);
      check("gap_busy", int'(bus.busy), 1);
      tick(1);
      check("read_io_valid", int'(bus.io_valid), 1);
      check("read_io_insn", int'(bus.io_insn), 'h5B);
      tick(1);
      check("wait_io_valid", int'(bus.io_valid), 0);
      tick(1);
      check("single_m_valid", int'(bus.m_valid), 1);
      check("single_m_re", int'($signed(bus.m_real)), -18645);
      check("single_m_im", int'($signed(bus.m_imag)), 1372);
      check("single_done", int'(bus.done_cnt), 1);
      bus.m_ready = 1'b1;
      tick(1);
      check("single_popped", int'(bus.m_valid), 0);
      clear_results();

      // back-to-back stream with free-running sink
      base = acc_cnt;
      set_smp(-665, -368); bus.s_valid = 1'b1; wait_accept("stream_acc0", base + 1);
      set_smp(541, 224);                       wait_accept("stream_acc1", base + 2);
      set_smp(425, -458);                      wait_accept("stream_acc2", base + 3);
      set_smp(189, 413);                       wait_accept("stream_acc3", base + 4);
      bus.s_valid = 1'b0;
      wait_results("stream_count", 4);
      check_res("stream0", 0, -6739, 20810);
      check_res("stream1", 1, 3352, -16516);
      check_res("stream2", 2, -15276, -9488);
      check_res("stream3", 3, 10627, -7611);
      for (int i = 1; i < 4; i++) begin
         if (i < res_cyc.size()) check("stream_period", res_cyc[i] - res_cyc[i-1], 5);
      end
      check("stream_done", int'(bus.done_cnt), 5);

      // sink stalled: only RES_DEPTH samples get in
      bus.m_ready = 1'b0;
      clear_results();
      base = acc_cnt;
      set_smp(-665, -368); bus.s_valid = 1'b1; wait_accept("bp_acc0", base + 1);
      set_smp(541, 224);                       wait_accept("bp_acc1", base + 2);
      set_smp(425, -458);
      tick(25);
      check("bp_third_held", acc_cnt, base + 2);
      check("bp_s_ready", int'(bus.s_ready), 0);
      check("bp_m_valid", int'(bus.m_valid), 1);
      check("bp_head_re", int'($signed(bus.m_real)), -6739);
      check("bp_busy", int'(bus.busy), 0);
      check("bp_done", int'(bus.done_cnt), 7);
      bus.m_ready = 1'b1;
      wait_accept("bp_acc2", base + 3);
      bus.s_valid = 1'b0;
      wait_results("bp_count", 3);
      check_res("bp0", 0, -6739, 20810);
      check_res("bp1", 1, 3352, -16516);
      check_res("bp2", 2, -15276, -9488);
      check("bp_done_final", int'(bus.done_cnt), 8);
      bus.m_ready = 1'b0;

      // cfg_start outside IDLE/RUN is ignored
      base = acc_cnt;
      set_smp(189, 413);
      bus.s_valid = 1'b1;
      wait_accept("ign_acc", base + 1);
      bus.s_valid = 1'b0;
      set_cfg(1, 1);
      bus.cfg_start = 1'b1;
      tick(1);
      check("ign_gap_insn", int'(bus.io_insn), 0);
      tick(1);
      check("ign_read_insn", int'(bus.io_insn), 'h5B);
      tick(1);
      check("ign_wait_insn", int'(bus.io_insn), 0);
      tick(1);
      bus.cfg_start = 1'b0;
      check("ign_done", int'(bus.done_cnt), 9);
      check("ign_m_re", int'($signed(bus.m_real)), 10627);
      check("ign_m_im", int'($signed(bus.m_imag)), -7611);
      check("ign_rs1_re", int'($signed(bus.io_rs1_real)), 189);

      // reset while in GAP with one result still queued
      set_smp(77, -645);
      bus.s_valid = 1'b1;
      wait_accept("rstgap_acc", base + 2);
      bus.s_valid = 1'b0;
      tick(1);
      check("rstgap_busy_before", int'(bus.busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("rstgap_busy", int'(bus.busy), 0);
      check("rstgap_m_valid", int'(bus.m_valid), 0);
      check("rstgap_done", int'(bus.done_cnt), 0);
      check("rstgap_rs1_re", int'(bus.io_rs1_real), 0);
      check("rstgap_io_valid", int'(bus.io_valid), 0);
      check("rstgap_s_ready", int'(bus.s_ready), 0);
      tick(1);
      reset = 1'b1;
      tick(1);

      set_cfg(-88, -452);
      bus.cfg_start = 1'b1;
      tick(1);
      bus.cfg_start = 1'b0;
      check("reinit_insn", int'(bus.io_insn), 'h0B);
      tick(1);
      base = acc_cnt;
      set_smp(425, -458);
      bus.s_valid = 1'b1;
      wait_accept("reinit_acc", base + 1);
      bus.s_valid = 1'b0;
      tick(4);
      check("reinit_m_valid", int'(bus.m_valid), 1);
      check("reinit_m_re", int'($signed(bus.m_real)), -15276);
      check("reinit_m_im", int'($signed(bus.m_imag)), -9488);
      check("reinit_done", int'(bus.done_cnt), 1);

      // re-init from RUN once drained
      bus.m_ready = 1'b1;
      tick(1);
      bus.m_ready = 1'b0;
      check("rerun_empty", int'(bus.m_valid), 0);
      bus.cfg_start = 1'b1;
      tick(1);
      bus.cfg_start = 1'b0;
      check("rerun_io_valid", int'(bus.io_valid), 1);
      check("rerun_insn", int'(bus.io_insn), 'h0B);
      check("rerun_done", int'(bus.done_cnt), 0);
      check("rerun_busy", int'(bus.busy), 1);
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

endmodule
